// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, default widths and buffer entry layout.
// Buffer entries carry the word together with the address it was fetched from.
package fetch_pkg;

  localparam int INSTR_WIDTH = 64;
  localparam int ADDR_WIDTH  = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DRAIN,
    ST_DONE
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_WIDTH-1:0]  addr;
    logic [INSTR_WIDTH-1:0] word;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Two-entry valid/ready output buffer with flush; head is registered, zero-cycle pop, push lands next cycle.
// The producer must not push while two entries are held; flush empties the buffer after any same-cycle pop.
module fetch_skid_buffer
  import fetch_pkg::*;
#(
  parameter int DATA_W = ADDR_WIDTH + INSTR_WIDTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush_i,
  input  logic              push_vld_i,
  input  logic [DATA_W-1:0] push_dat_i,
  output logic              out_vld_o,
  output logic [DATA_W-1:0] out_dat_o,
  input  logic              out_rdy_i,
  output logic [1:0]        count_o
);

  logic [DATA_W-1:0] ent0_q, ent0_d;
  logic [DATA_W-1:0] ent1_q, ent1_d;
  logic [1:0]        cnt_q, cnt_d;
  logic              pop;

  assign out_vld_o = (cnt_q != 2'd0);
  assign out_dat_o = ent0_q;
  assign count_o   = cnt_q;
  assign pop       = out_vld_o & out_rdy_i;

  always_comb begin
    ent0_d = ent0_q;
    ent1_d = ent1_q;
    cnt_d  = cnt_q;
    case ({push_vld_i, pop})
      2'b10: begin
        if (cnt_q == 2'd0) ent0_d = push_dat_i;
        else               ent1_d = push_dat_i;
        cnt_d = cnt_q + 2'd1;
      end
      2'b01: begin
        ent0_d = ent1_q;
        cnt_d  = cnt_q - 2'd1;
      end
      2'b11: begin
        if (cnt_q == 2'd1) begin
          ent0_d = push_dat_i;
        end else begin
          ent0_d = ent1_q;
          ent1_d = push_dat_i;
        end
      end
      default: ;
    endcase
    if (flush_i) cnt_d = 2'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Streams program words from local memory to the core: start->first valid in 2 cycles, redirect->new word in 2.
// Holds outputs under backpressure with at most two words buffered; FETCH_PERF_COUNTERS_EN adds fetch/redirect counters.
module instruction_fetch_unit #(
  parameter int INSTR_WIDTH = fetch_pkg::INSTR_WIDTH,
  parameter int ADDR_WIDTH  = fetch_pkg::ADDR_WIDTH
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   loadEnable,
  input  logic [ADDR_WIDTH-1:0]  loadAddress,
  input  logic [INSTR_WIDTH-1:0] loadData,
  input  logic [ADDR_WIDTH:0]    programLength,
  input  logic                   start,
  input  logic                   PCChangeEnable,
  input  logic [ADDR_WIDTH-1:0]  target,
  output logic [INSTR_WIDTH-1:0] instruction,
  output logic                   instructionValid,
  input  logic                   instructionReady,
  output logic [ADDR_WIDTH-1:0]  programCounter,
  output logic                   busy,
  output logic                   done
`ifdef FETCH_PERF_COUNTERS_EN
  ,
  output logic [31:0]            fetchCount,
  output logic [15:0]            redirectCount
`endif
);
  import fetch_pkg::*;

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [INSTR_WIDTH-1:0] mem [DEPTH];

  fetch_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0]   pc_q, pc_d;
  logic [ADDR_WIDTH:0]     len_q, len_d;
  logic [ADDR_WIDTH:0]     len_m1;
  logic                    idle_like, active, redirect, accept_start;
  logic                    issue, last_issue, handshake, drain_empty;
  logic [1:0]              buf_cnt;
  logic [ADDR_WIDTH+INSTR_WIDTH-1:0] push_dat, out_dat;

  assign idle_like    = (state_q == ST_IDLE) || (state_q == ST_DONE);
  assign active       = (state_q == ST_FETCH) || (state_q == ST_DRAIN);
  assign redirect     = PCChangeEnable & active;
  assign accept_start = start & idle_like;
  assign len_m1       = len_q - {{ADDR_WIDTH{1'b0}}, 1'b1};
  assign last_issue   = ({1'b0, pc_q} == len_m1);
  assign issue        = (state_q == ST_FETCH) && (buf_cnt < 2'd2) && !redirect;
  assign handshake    = instructionValid & instructionReady;
  assign drain_empty  = (buf_cnt == 2'd0) || ((buf_cnt == 2'd1) && handshake);

  // Program image survives reset; writes only land while the unit is not fetching.
  always_ff @(posedge clk) begin
    if (loadEnable && idle_like) mem[loadAddress] <= loadData;
  end

  assign push_dat = {pc_q, mem[pc_q]};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    len_d   = len_q;
    if (redirect) begin
      pc_d    = target;
      state_d = ({1'b0, target} < len_q) ? ST_FETCH : ST_DONE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (accept_start) begin
            len_d   = programLength;
            pc_d    = '0;
            state_d = (programLength == '0) ? ST_DONE : ST_FETCH;
          end
        end
        ST_FETCH: begin
          if (issue) begin
            pc_d = pc_q + {{(ADDR_WIDTH-1){1'b0}}, 1'b1};
            if (last_issue) state_d = ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (drain_empty) state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
    end
  end

  fetch_skid_buffer #(
    .DATA_W(ADDR_WIDTH + INSTR_WIDTH)
  ) u_buf (
    .clk       (clk),
    .reset     (reset),
    .flush_i   (redirect),
    .push_vld_i(issue),
    .push_dat_i(push_dat),
    .out_vld_o (instructionValid),
    .out_dat_o (out_dat),
    .out_rdy_i (instructionReady),
    .count_o   (buf_cnt)
  );

  assign instruction    = out_dat[INSTR_WIDTH-1:0];
  assign programCounter = out_dat[ADDR_WIDTH+INSTR_WIDTH-1:INSTR_WIDTH];
  assign busy           = active;
  assign done           = (state_q == ST_DONE);

`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0] fetch_cnt_q;
  logic [15:0] redir_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || accept_start) begin
      fetch_cnt_q <= '0;
      redir_cnt_q <= '0;
    end else begin
      if (handshake && (fetch_cnt_q != '1)) fetch_cnt_q <= fetch_cnt_q + 32'd1;
      if (redirect && (redir_cnt_q != '1))  redir_cnt_q <= redir_cnt_q + 16'd1;
    end
  end

  assign fetchCount    = fetch_cnt_q;
  assign redirectCount = redir_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a scoreboard queue of expected {pc, word} is filled at stimulus time
// and drained by an independent monitor on every accepted handshake; cycle-exact checks run in the main thread.
module tb_instruction_fetch_unit;
  import fetch_pkg::*;

  localparam int IW = 64;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          loadEnable = 1'b0;
  logic [AW-1:0] loadAddress = '0;
  logic [IW-1:0] loadData = '0;
  logic [AW:0]   programLength = '0;
  logic          start = 1'b0;
  logic          PCChangeEnable = 1'b0;
  logic [AW-1:0] target = '0;
  logic [IW-1:0] instruction;
  logic          instructionValid;
  logic          instructionReady = 1'b1;
  logic [AW-1:0] programCounter;
  logic          busy;
  logic          done;
`ifdef FETCH_PERF_COUNTERS_EN
  logic [31:0]   fetchCount;
  logic [15:0]   redirectCount;
`endif

  always #5 clk = ~clk;

  instruction_fetch_unit #(.INSTR_WIDTH(IW), .ADDR_WIDTH(AW)) dut (
    .clk             (clk),
    .reset           (reset),
    .loadEnable      (loadEnable),
    .loadAddress     (loadAddress),
    .loadData        (loadData),
    .programLength   (programLength),
    .start           (start),
    .PCChangeEnable  (PCChangeEnable),
    .target          (target),
    .instruction     (instruction),
    .instructionValid(instructionValid),
    .instructionReady(instructionReady),
    .programCounter  (programCounter),
    .busy            (busy),
    .done            (done)
`ifdef FETCH_PERF_COUNTERS_EN
    ,
    .fetchCount      (fetchCount),
    .redirectCount   (redirectCount)
`endif
  );

  fetch_entry_t  exp_q[$];
  logic [IW-1:0] img [256];
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int a);
    fetch_entry_t e;
    e.addr = AW'(a);
    e.word = img[a];
    exp_q.push_back(e);
  endtask

  task automatic load_word(input int a, input logic [IW-1:0] d);
    loadEnable  = 1'b1;
    loadAddress = AW'(a);
    loadData    = d;
    img[a]      = d;
    next_cycle();
    loadEnable  = 1'b0;
  endtask

  // Returns in cycle 1 of the run (start was sampled at the end of cycle 0).
  task automatic start_run(input int len, input bit with_exp);
    programLength = (AW+1)'(len);
    start = 1'b1;
    if (with_exp) for (int i = 0; i < len; i++) push_exp(i);
    next_cycle();
    start = 1'b0;
  endtask

  task automatic wait_done(input int maxc, input string name);
    int c;
    c = 0;
    @(negedge clk);
    while (!done && c < maxc) begin
      @(negedge clk);
      c++;
    end
    check(name, 64'(done), 64'd1);
    check({name, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Scoreboard monitor plus hold-stability check under backpressure.
  initial begin
    logic          hold;
    logic [AW-1:0] hpc;
    logic [IW-1:0] hins;
    fetch_entry_t  e;
    hold = 1'b0;
    hpc  = '0;
    hins = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        hold = 1'b0;
      end else begin
        if (hold && instructionValid) begin
          check("hold_pc", 64'(programCounter), 64'(hpc));
          check("hold_word", instruction, hins);
        end
        if (instructionValid && instructionReady) begin
          if (exp_q.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected_word: got pc %h word %h, required no word", programCounter, instruction);
          end else begin
            e = exp_q.pop_front();
            check("sb_pc", 64'(programCounter), 64'(e.addr));
            check("sb_word", instruction, e.word);
          end
        end
        hold = instructionValid && !instructionReady;
        hpc  = programCounter;
        hins = instruction;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    next_cycle();
    next_cycle();
    @(negedge clk);
    check("rst_valid", 64'(instructionValid), 64'd0);
    check("rst_instr", instruction, 64'd0);
    check("rst_pc", 64'(programCounter), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) load_word(i, 64'h1111_1111_1111_1111 * 64'(i + 1));

    // Basic streaming, ready held high.
    start_run(4, 1'b1);
    @(negedge clk);
    check("t1_c1_valid", 64'(instructionValid), 64'd0);
    check("t1_c1_busy", 64'(busy), 64'd1);
    next_cycle();
    @(negedge clk);
    check("t1_c2_valid", 64'(instructionValid), 64'd1);
    check("t1_c2_pc", 64'(programCounter), 64'd0);
    for (int c = 3; c <= 5; c++) begin
      next_cycle();
      @(negedge clk);
      check("t1_stream_valid", 64'(instructionValid), 64'd1);
    end
    check("t1_c5_done", 64'(done), 64'd0);
    next_cycle();
    @(negedge clk);
    check("t1_c6_done", 64'(done), 64'd1);
    check("t1_c6_valid", 64'(instructionValid), 64'd0);
    check("t1_c6_busy", 64'(busy), 64'd0);
    check("t1_sb_empty", 64'(exp_q.size()), 64'd0);
`ifdef FETCH_PERF_COUNTERS_EN
    check("t1_fetch_count", 64'(fetchCount), 64'd4);
    check("t1_redirect_count", 64'(redirectCount), 64'd0);
`endif

    // Backpressure: ready low in cycles 3..6.
    next_cycle();
    start_run(4, 1'b1);
    next_cycle();
    next_cycle();
    instructionReady = 1'b0;
    @(negedge clk);
    check("t2_c3_pc", 64'(programCounter), 64'd1);
    for (int c = 4; c <= 6; c++) next_cycle();
    @(negedge clk);
    check("t2_c6_valid", 64'(instructionValid), 64'd1);
    check("t2_c6_pc", 64'(programCounter), 64'd1);
    next_cycle();
    instructionReady = 1'b1;
    wait_done(20, "t2_done");

    // Redirect to 0x10 while PC 2 is accepted.
    next_cycle();
    for (int i = 0; i < 32; i++) load_word(i, 64'hC0DE_0000_0000_0000 | 64'(i));
    for (int i = 0; i < 3; i++) push_exp(i);
    for (int i = 16; i < 32; i++) push_exp(i);
    start_run(32, 1'b0);
    next_cycle();
    next_cycle();
    next_cycle();
    PCChangeEnable = 1'b1;
    target = 8'h10;
    @(negedge clk);
    check("t3_c4_pc", 64'(programCounter), 64'd2);
    next_cycle();
    PCChangeEnable = 1'b0;
    @(negedge clk);
    check("t3_c5_valid", 64'(instructionValid), 64'd0);
    next_cycle();
    @(negedge clk);
    check("t3_c6_valid", 64'(instructionValid), 64'd1);
    check("t3_c6_pc", 64'(programCounter), 64'h10);
    wait_done(40, "t3_done");

    // Redirect beyond program length ends the run.
    next_cycle();
    start_run(8, 1'b0);
    PCChangeEnable = 1'b1;
    target = 8'h20;
    @(negedge clk);
    check("t4_c1_valid", 64'(instructionValid), 64'd0);
    next_cycle();
    PCChangeEnable = 1'b0;
    @(negedge clk);
    check("t4_c2_done", 64'(done), 64'd1);
    check("t4_c2_valid", 64'(instructionValid), 64'd0);

    // Reset in cycle 4, then restart with the retained image.
    next_cycle();
    start_run(4, 1'b1);
    next_cycle();
    next_cycle();
    next_cycle();
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("t5_valid", 64'(instructionValid), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    check("t5_done", 64'(done), 64'd0);
    check("t5_pc", 64'(programCounter), 64'd0);
    check("t5_instr", instruction, 64'd0);
    next_cycle();
    start_run(4, 1'b1);
    wait_done(20, "t5_restart_done");

    // Load during FETCH is ignored; zero-length start goes straight to DONE.
    next_cycle();
    start_run(4, 1'b1);
    loadEnable  = 1'b1;
    loadAddress = 8'd3;
    loadData    = 64'hDEAD_BEEF_DEAD_BEEF;
    next_cycle();
    loadEnable  = 1'b0;
    wait_done(20, "t6_done");
    next_cycle();
    start_run(0, 1'b0);
    @(negedge clk);
    check("t6_len0_done", 64'(done), 64'd1);
    check("t6_len0_valid", 64'(instructionValid), 64'd0);
    check("t6_len0_busy", 64'(busy), 64'd0);
    next_cycle();
    @(negedge clk);
    check("t6_len0_valid2", 64'(instructionValid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
